// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU op codes, branch funct3 codes
// and the multiplier FSM state type.
package exec_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/exec_alu.sv
// Combinational XLEN-wide ALU plus branch comparator (rs1 vs rs2).
// Under EXEC_MUL_EN the MUL code is legal here; the product comes from the top.
module exec_alu
  import exec_pkg::*;
#(
  parameter int XLEN = 64,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [3:0]      i_alu_ctrl,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_result,
  output logic            o_illegal,
  output logic            o_cond
);

  logic [SHW-1:0] w_shamt;
  assign w_shamt = i_b[SHW-1:0];

  // ALU operation select
  always_comb begin
    o_result  = '0;
    o_illegal = 1'b0;
    case (i_alu_ctrl)
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_ADD:  o_result = i_a + i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SLL:  o_result = i_a << w_shamt;
      ALU_SRL:  o_result = i_a >> w_shamt;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_SRA:  o_result = $signed(i_a) >>> w_shamt;
      ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
`ifdef EXEC_MUL_EN
      ALU_MUL:  o_result = '0;
`else
      ALU_MUL:  o_illegal = 1'b1;
`endif
      default:  o_illegal = 1'b1;
    endcase
  end

  // Branch condition; funct3 010/011 are never taken
  always_comb begin
    o_cond = 1'b0;
    case (i_funct3)
      BR_EQ:   o_cond = (i_rs1 == i_rs2);
      BR_NE:   o_cond = (i_rs1 != i_rs2);
      BR_LT:   o_cond = ($signed(i_rs1) < $signed(i_rs2));
      BR_GE:   o_cond = ($signed(i_rs1) >= $signed(i_rs2));
      BR_LTU:  o_cond = (i_rs1 < i_rs2);
      BR_GEU:  o_cond = (i_rs1 >= i_rs2);
      default: o_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_unit_pipe.sv
// Execute stage with one registered valid/ready output slot.
// Macro EXEC_MUL_EN adds an iterative shift-add multiplier for ALU_MUL.
module exec_unit_pipe
  import exec_pkg::*;
#(
  parameter int XLEN = 64,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [3:0]      alu_ctrl,
  input  logic            alu_src,
  input  logic            branch,
  input  logic [2:0]      funct3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic [XLEN-1:0] branch_target,
  output logic            branch_taken,
  output logic            illegal_op
);

  logic [XLEN-1:0] w_b, w_alu, w_target;
  logic            w_illegal, w_cond, w_taken, w_idle, w_xfer, w_drain, w_start_mul;

  logic            r_out_valid, r_zero, r_taken, r_illegal;
  logic [XLEN-1:0] r_result, r_target;

  assign w_b      = alu_src ? imm : rs2_data;
  assign w_target = pc + (imm << 1);
  assign w_taken  = branch & w_cond;
  assign w_xfer   = in_valid & in_ready;
  assign w_drain  = r_out_valid & out_ready;
  assign in_ready = ~reset & w_idle & (~r_out_valid | out_ready);

  exec_alu #(.XLEN(XLEN)) u_alu (
    .i_a        (rs1_data),
    .i_b        (w_b),
    .i_rs1      (rs1_data),
    .i_rs2      (rs2_data),
    .i_alu_ctrl (alu_ctrl),
    .i_funct3   (funct3),
    .o_result   (w_alu),
    .o_illegal  (w_illegal),
    .o_cond     (w_cond)
  );

`ifdef EXEC_MUL_EN
  state_e          r_state;
  logic [XLEN-1:0] r_mcand, r_mplier, r_acc, r_mul_target;
  logic [SHW-1:0]  r_cnt;
  logic            r_mul_taken;
  logic [XLEN-1:0] w_mul_final;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_start_mul = w_xfer & (alu_ctrl == ALU_MUL);
  // DONE folds in the last partial product, so MUL only runs XLEN-1 steps
  assign w_mul_final = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Multiplier FSM: capture operands, shift-add, hand off in DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_mul_target <= '0;
      r_mul_taken  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_mul) begin
            r_mcand      <= rs1_data;
            r_mplier     <= w_b;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_mul_target <= w_target;
            r_mul_taken  <= w_taken;
            r_state      <= ST_MUL;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_MUL: begin
          r_acc    <= w_mul_final;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + SHW'(1);
          if (r_cnt == SHW'(XLEN - 2)) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_MUL;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
`else
  assign w_idle      = 1'b1;
  assign w_start_mul = 1'b0;
`endif

  // Output slot: load on accept or multiply completion, clear on drain
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_target    <= '0;
      r_taken     <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_xfer && !w_start_mul) begin
      r_out_valid <= 1'b1;
      r_result    <= w_alu;
      r_zero      <= (w_alu == '0);
      r_target    <= w_target;
      r_taken     <= w_taken;
      r_illegal   <= w_illegal;
`ifdef EXEC_MUL_EN
    end else if (r_state == ST_DONE) begin
      r_out_valid <= 1'b1;
      r_result    <= w_mul_final;
      r_zero      <= (w_mul_final == '0);
      r_target    <= r_mul_target;
      r_taken     <= r_mul_taken;
      r_illegal   <= 1'b0;
`endif
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_valid     = r_out_valid;
  assign alu_result    = r_result;
  assign zero          = r_zero;
  assign branch_target = r_target;
  assign branch_taken  = r_taken;
  assign illegal_op    = r_illegal;

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Self-checking bench for exec_unit_pipe: directed scenarios plus a random
// handshake run against a behavioural model of the execute stage.
module tb_exec_unit_pipe;

  localparam int XLEN = 64;
  localparam int OW   = 2 * XLEN + 3;
  typedef logic [XLEN-1:0] word_t;

  logic clk = 1'b0;
  logic reset, in_valid, out_ready, alu_src, branch;
  logic in_ready, out_valid, zero, branch_taken, illegal_op;
  word_t pc, imm, rs1_data, rs2_data, alu_result, branch_target;
  logic [3:0] alu_ctrl;
  logic [2:0] funct3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exec_unit_pipe #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .imm(imm), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_ctrl(alu_ctrl), .alu_src(alu_src), .branch(branch), .funct3(funct3),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .zero(zero), .branch_target(branch_target), .branch_taken(branch_taken),
    .illegal_op(illegal_op)
  );

  wire [OW-1:0] obs = {alu_result, zero, branch_target, branch_taken, illegal_op};

  // Reference: {result, zero, target, taken, illegal} from the instruction semantics
  function automatic logic [OW-1:0] ref_model(input logic [3:0] op, input word_t a,
      input word_t r2, input word_t im, input word_t p, input logic src,
      input logic br, input logic [2:0] f3);
    word_t b, r;
    logic ill, c;
    int sh;
    b = src ? im : r2;
    sh = int'(b % XLEN);
    r = '0;
    ill = 1'b0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a ^ b;
      4'd4:  r = a << sh;
      4'd5:  r = a >> sh;
      4'd6:  r = a - b;
      4'd7:  r = $signed(a) >>> sh;
      4'd8:  r = ($signed(a) < $signed(b)) ? word_t'(1) : word_t'(0);
      4'd9:  r = (a < b) ? word_t'(1) : word_t'(0);
`ifdef EXEC_MUL_EN
      4'd10: r = a * b;
`endif
      default: ill = 1'b1;
    endcase
    case (f3)
      3'd0: c = (a == r2);
      3'd1: c = (a != r2);
      3'd4: c = $signed(a) < $signed(r2);
      3'd5: c = $signed(a) >= $signed(r2);
      3'd6: c = a < r2;
      3'd7: c = a >= r2;
      default: c = 1'b0;
    endcase
    return {r, (r == '0), p + im * 2, br & c, ill};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input word_t a, input word_t r2,
      input word_t im, input word_t p, input logic src, input logic br, input logic [2:0] f3);
    alu_ctrl = op; rs1_data = a; rs2_data = r2; imm = im; pc = p;
    alu_src = src; branch = br; funct3 = f3;
    #1;
  endtask

  function automatic logic [OW-1:0] cur_exp();
    return ref_model(alu_ctrl, rs1_data, rs2_data, imm, pc, alu_src, branch, funct3);
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    drive(4'd2, 64'd11, 64'd22, 64'd3, 64'h40, 1'b0, 1'b1, 3'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL reset_hold: out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
      end
    end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++;
    if (obs !== '0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: obs=%h out_valid=%b required all zero", obs, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] e;
    out_ready = 1'b1; in_valid = 1'b1;
    drive(4'd2, 64'd5, 64'd0, -64'sd3, 64'h0, 1'b1, 1'b0, 3'd0);
    e = cur_exp();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready: in_ready=%b required 1", in_ready); end
    step();
    drive(4'd6, 64'd7, 64'd7, 64'd0, 64'h0, 1'b0, 1'b0, 3'd0);
    n_checks++;
    if (out_valid !== 1'b1 || obs !== e || alu_result !== 64'd2) begin
      n_fail++; $display("FAIL add_result: v=%b res=%h required v=1 res=2", out_valid, alu_result);
    end
    e = cur_exp();
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || obs !== e || zero !== 1'b1 || alu_result !== 64'd0) begin
      n_fail++; $display("FAIL sub_zero: v=%b res=%h zero=%b required v=1 res=0 zero=1", out_valid, alu_result, zero);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_branch();
    logic [2:0] f3s [2];
    logic       tk  [2];
    f3s[0] = 3'd4; f3s[1] = 3'd6; tk[0] = 1'b1; tk[1] = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      drive(4'd2, -64'sd1, 64'd1, 64'd8, 64'h1000, 1'b0, 1'b1, f3s[i]);
      step();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || branch_taken !== tk[i] || branch_target !== 64'h1010) begin
        n_fail++; $display("FAIL branch_%0d: taken=%b tgt=%h required taken=%b tgt=1010", i, branch_taken, branch_target, tk[i]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] ea, eb;
    out_ready = 1'b1; in_valid = 1'b1;
    drive(4'd3, 64'hDEAD_BEEF_0000_1234, 64'h0F0F, 64'd0, 64'h2000, 1'b0, 1'b1, 3'd1);
    ea = cur_exp();
    step();
    out_ready = 1'b0;
    drive(4'd1, 64'h1, 64'h2, 64'h10, 64'h3000, 1'b1, 1'b0, 3'd0);
    eb = cur_exp();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== ea) begin
        n_fail++; $display("FAIL bp_hold_%0d: rdy=%b v=%b obs=%h required rdy=0 v=1 obs=%h", i, in_ready, out_valid, obs, ea);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready: in_ready=%b required 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || obs !== eb) begin
      n_fail++; $display("FAIL bp_accept: v=%b obs=%h required v=1 obs=%h", out_valid, obs, eb);
    end
    step();
  endtask

  task automatic test_shifts();
    word_t req [2];
    req[0] = 64'hF000_0000_0000_0000; req[1] = 64'h2468;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      if (i == 0) drive(4'd7, 64'h8000_0000_0000_0000, 64'h43, 64'd0, 64'd0, 1'b0, 1'b0, 3'd0);
      else        drive(4'd4, 64'h1234, 64'd65, 64'd0, 64'd0, 1'b0, 1'b0, 3'd0);
      step();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || alu_result !== req[i]) begin
        n_fail++; $display("FAIL shift_%0d: res=%h required %h", i, alu_result, req[i]);
      end
      step();
    end
  endtask

  task automatic test_mul();
    int lat;
    out_ready = 1'b1; in_valid = 1'b1;
    drive(4'd10, 64'hFFFF_FFFF, 64'd3, 64'd0, 64'h100, 1'b0, 1'b0, 3'd0);
    step();
    in_valid = 1'b0;
`ifdef EXEC_MUL_EN
    lat = 1;
    while (!out_valid && lat < XLEN + 10) begin
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mul_busy: in_ready=%b required 0 at %0d", in_ready, lat); end
      step();
      lat++;
    end
    n_checks++;
    if (lat != XLEN + 1 || alu_result !== 64'h2_FFFF_FFFD || illegal_op !== 1'b0) begin
      n_fail++; $display("FAIL mul_result: lat=%0d res=%h ill=%b required lat=%0d res=2fffffffd ill=0", lat, alu_result, illegal_op, XLEN + 1);
    end
    step();
    in_valid = 1'b1;
    drive(4'd10, 64'd9, 64'd9, 64'd0, 64'd0, 1'b0, 1'b0, 3'd0);
    step();
    in_valid = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < XLEN + 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mul_abort: out_valid=%b required 0 at %0d", out_valid, i); end
      step();
    end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mul_abort_idle: in_ready=%b required 1", in_ready); end
`else
    lat = 1;
    n_checks++;
    if (out_valid !== 1'b1 || illegal_op !== 1'b1 || alu_result !== 64'd0) begin
      n_fail++; $display("FAIL mul_illegal: v=%b ill=%b res=%h lat=%0d required v=1 ill=1 res=0", out_valid, illegal_op, alu_result, lat);
    end
    step();
`endif
  endtask

  task automatic test_random();
    logic          m_valid;
    logic [OW-1:0] m_exp;
    logic [3:0]    op;
    word_t         a;
    m_valid = 1'b0;
    m_exp = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op = 4'($urandom_range(0, 15));
`ifdef EXEC_MUL_EN
      if (op == 4'd10) op = 4'd2;
`endif
      a = {$urandom, $urandom};
      drive(op, a, ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom},
            ($urandom_range(0, 1) == 0) ? word_t'($urandom_range(0, 127)) : {$urandom, $urandom},
            {$urandom, $urandom}, 1'($urandom), 1'($urandom), 3'($urandom));
      n_checks++;
      if (in_ready !== (!m_valid || out_ready) || out_valid !== m_valid || (m_valid && obs !== m_exp)) begin
        n_fail++; $display("FAIL random_%0d: rdy=%b v=%b obs=%h required v=%b obs=%h", cyc, in_ready, out_valid, obs, m_valid, m_exp);
      end
      if (in_valid && (!m_valid || out_ready)) begin
        m_exp = cur_exp();
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_branch();
    test_backpressure();
    test_shifts();
    test_random();
    test_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
